lsu: RTL

LSU -- requirements
Module: lsu

---
 rtl/lsu_pkg.sv | 58 +++++
 rtl/lsu_align.sv | 50 +++++
 rtl/lsu.sv | 110 +++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// LSU shared definitions: access encodings, FSM states,
// byte-enable patterns and the access legality check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } lsuState_t;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_B    = 4'b0001;
  localparam logic [3:0] BE_H    = 4'b0011;
  localparam logic [3:0] BE_W    = 4'b1111;

  function automatic logic accessOk(
    input logic       rd,
    input logic       wr,
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic sizeOk;
    logic alignOk;
    sizeOk  = 1'b0;
    alignOk = 1'b0;
    case (f3)
      F3_B: begin
        sizeOk  = 1'b1;
        alignOk = 1'b1;
      end
      F3_BU: begin
        sizeOk  = rd;
        alignOk = 1'b1;
      end
      F3_H: begin
        sizeOk  = 1'b1;
        alignOk = !off[0];
      end
      F3_HU: begin
        sizeOk  = rd;
        alignOk = !off[0];
      end
      F3_W: begin
        sizeOk  = 1'b1;
        alignOk = (off == 2'b00);
      end
      default: ;
    endcase
    return (rd ^ wr) && sizeOk && alignOk;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// LSU lane logic: store byte-enable/data steering and
// load byte/half extraction with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  stF3,
  input  logic [1:0]  stOff,
  input  logic [31:0] stData,
  output logic [3:0]  stBe,
  output logic [31:0] stWdata,
  input  logic [2:0]  ldF3,
  input  logic [1:0]  ldOff,
  input  logic [31:0] ldWord,
  output logic [31:0] ldData
);

  logic [7:0]  ldByte;
  logic [15:0] ldHalf;

  always_comb begin
    stBe    = BE_NONE;
    stWdata = stData;
    unique case (1'b1)
      (stF3[1:0] == 2'b00): begin
        stBe    = BE_B << stOff;
        stWdata = {4{stData[7:0]}};
      end
      (stF3[1:0] == 2'b01): begin
        stBe    = BE_H << {stOff[1], 1'b0};
        stWdata = {2{stData[15:0]}};
      end
      (stF3[1:0] == 2'b10): stBe = BE_W;
      default: ;
    endcase
  end

  always_comb begin
    ldByte = ldWord[{ldOff, 3'b000} +: 8];
    ldHalf = ldOff[1] ? ldWord[31:16] : ldWord[15:0];
    ldData = ldWord;
    unique case (1'b1)
      (ldF3 == F3_B):  ldData = {{24{ldByte[7]}}, ldByte};
      (ldF3 == F3_BU): ldData = {24'b0, ldByte};
      (ldF3 == F3_H):  ldData = {{16{ldHalf[15]}}, ldHalf};
      (ldF3 == F3_HU): ldData = {16'b0, ldHalf};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one memory-stage access at a time,
// drives a req/gnt/rvalid data bus and stalls the pipeline meanwhile.
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemReadM,
  input  logic              MemWriteM,
  input  logic [2:0]        Funct3M,
  input  logic [31:0]       ALUResultM,
  input  logic [31:0]       WriteDataM,
  output logic [31:0]       ReadDataM,
  output logic              StallM,
  output logic              ErrM,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  lsuState_t   state;
  logic [2:0]  f3Q;
  logic [1:0]  offQ;
  logic [3:0]  stBe;
  logic [31:0] stWdata;
  logic [31:0] ldData;
  logic        access;
  logic        legal;
  logic        accept;

  assign access = MemReadM | MemWriteM;
  assign legal  = accessOk(MemReadM, MemWriteM, Funct3M, ALUResultM[1:0]);
  assign accept = (state == S_IDLE) && access && legal;
  assign ErrM   = reset && (state == S_IDLE) && access && !legal;

  lsu_align uAlign (
    .stF3    (Funct3M),
    .stOff   (ALUResultM[1:0]),
    .stData  (WriteDataM),
    .stBe    (stBe),
    .stWdata (stWdata),
    .ldF3    (f3Q),
    .ldOff   (offQ),
    .ldWord  (mem_rdata),
    .ldData  (ldData)
  );

  // Stall drops in the completion cycle so the pipeline advances on that edge
  always_comb begin
    StallM = 1'b0;
    if (reset) begin
      unique case (state)
        S_IDLE:  StallM = accept;
        S_REQ:   StallM = !(mem_gnt && mem_we);
        S_WAIT:  StallM = !mem_rvalid;
        default: StallM = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= BE_NONE;
      mem_wdata <= '0;
      ReadDataM <= '0;
      f3Q       <= '0;
      offQ      <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            state     <= S_REQ;
            mem_req   <= 1'b1;
            mem_we    <= MemWriteM;
            mem_addr  <= ADDR_W'({ALUResultM[31:2], 2'b00});
            mem_be    <= stBe;
            mem_wdata <= stWdata;
            f3Q       <= Funct3M;
            offQ      <= ALUResultM[1:0];
          end
        end
        S_REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= mem_we ? S_IDLE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            ReadDataM <= ldData;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
